// File: rtl/strided_read_engine_if.sv
// Handshake/bus bundle between the AFU control side and strided_read_engine.
// Signal prefixes are from the engine's point of view (i_ into the engine, o_ out of it).
interface strided_read_engine_if #(
  parameter int ADDR_W   = 42,
  parameter int STRIDE_W = 16,
  parameter int MDATA_W  = 16
);
  logic                i_stall;
  logic                i_start;
  logic [ADDR_W-1:0]   i_start_addr;
  logic [31:0]         i_num_cls;
  logic [STRIDE_W-1:0] i_stride;
  logic                i_ctrl_poll_req;
  logic [ADDR_W-1:0]   i_ctrl_addr;
  logic                i_ctrl_ack;
  logic                i_rsp_valid;
  logic [MDATA_W-1:0]  i_rsp_mdata;
  logic                o_rd_valid;
  logic [ADDR_W-1:0]   o_rd_addr;
  logic [MDATA_W-1:0]  o_rd_mdata;
  logic                o_busy;
  logic                o_run_done;
  logic [8:0]          o_outstanding;
  logic [31:0]         o_perf_run_cycles;
  logic [31:0]         o_perf_stall_cycles;

  modport master (
    output i_stall, i_start, i_start_addr, i_num_cls, i_stride,
           i_ctrl_poll_req, i_ctrl_addr, i_ctrl_ack, i_rsp_valid, i_rsp_mdata,
    input  o_rd_valid, o_rd_addr, o_rd_mdata, o_busy, o_run_done, o_outstanding,
           o_perf_run_cycles, o_perf_stall_cycles
  );

  modport slave (
    input  i_stall, i_start, i_start_addr, i_num_cls, i_stride,
           i_ctrl_poll_req, i_ctrl_addr, i_ctrl_ack, i_rsp_valid, i_rsp_mdata,
    output o_rd_valid, o_rd_addr, o_rd_mdata, o_busy, o_run_done, o_outstanding,
           o_perf_run_cycles, o_perf_stall_cycles
  );
endinterface

// File: rtl/strided_read_engine.sv
// Strided cache-line read engine: one run of num_cls reads with credit-bounded issue plus idle control polls.
// Optional perf counters via STRIDED_READ_ENGINE_PERF_EN; request latency 1 cycle, no issue while stall is high.
module strided_read_engine #(
  parameter int   ADDR_W          = 42,
  parameter int   MAX_OUTSTANDING = 64,
  parameter int   STRIDE_W        = 16,
  parameter int   MDATA_W         = 16,
  parameter logic RUN_TAG         = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  strided_read_engine_if.slave io_bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam int         SEQ_W   = MDATA_W - 1;
  localparam logic [8:0] MAX_OUT = 9'(MAX_OUTSTANDING);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_cur_addr;
  logic [31:0]         r_remaining;
  logic [STRIDE_W-1:0] r_stride;
  logic [SEQ_W-1:0]    r_seq;
  logic [8:0]          r_outstanding;
  logic                r_poll_lock;
  logic                r_rd_valid;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [MDATA_W-1:0]  r_rd_mdata;

  logic w_start_ok;
  logic w_run_issue;
  logic w_ctrl_issue;
  logic w_rsp_run;

  assign w_start_ok   = (r_state == S_IDLE) && io_bus.i_start;
  assign w_run_issue  = (r_state == S_ISSUE) && !io_bus.i_stall &&
                        (r_remaining != 32'd0) && (r_outstanding < MAX_OUT);
  // start takes priority over a poll raised in the same cycle
  assign w_ctrl_issue = (r_state == S_IDLE) && !io_bus.i_start && !r_poll_lock &&
                        !io_bus.i_stall && io_bus.i_ctrl_poll_req;
  assign w_rsp_run    = io_bus.i_rsp_valid && (io_bus.i_rsp_mdata[MDATA_W-1] == RUN_TAG) &&
                        (r_outstanding != 9'd0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (io_bus.i_start) begin
          w_state_nxt = (io_bus.i_num_cls != 32'd0) ? S_ISSUE : S_DONE;
        end
      end
      S_ISSUE: begin
        if (w_run_issue && (r_remaining == 32'd1)) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_outstanding == 9'd0) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_stride    <= '0;
      r_seq       <= '0;
    end else if (w_start_ok) begin
      r_cur_addr  <= io_bus.i_start_addr;
      r_remaining <= io_bus.i_num_cls;
      r_stride    <= io_bus.i_stride;
      r_seq       <= '0;
    end else if (w_run_issue) begin
      r_cur_addr  <= r_cur_addr + ADDR_W'(r_stride);
      r_remaining <= r_remaining - 32'd1;
      r_seq       <= r_seq + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rd_valid <= 1'b0;
      r_rd_addr  <= '0;
      r_rd_mdata <= '0;
    end else begin
      r_rd_valid <= w_run_issue || w_ctrl_issue;
      if (w_run_issue) begin
        r_rd_addr  <= r_cur_addr;
        r_rd_mdata <= {RUN_TAG, r_seq};
      end else if (w_ctrl_issue) begin
        r_rd_addr  <= io_bus.i_ctrl_addr;
        r_rd_mdata <= {~RUN_TAG, SEQ_W'(0)};
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_outstanding <= '0;
    end else begin
      case ({w_run_issue, w_rsp_run})
        2'b10:   r_outstanding <= r_outstanding + 9'd1;
        2'b01:   r_outstanding <= r_outstanding - 9'd1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_poll_lock <= 1'b0;
    end else if (w_ctrl_issue) begin
      r_poll_lock <= 1'b1;
    end else if (io_bus.i_ctrl_ack) begin
      r_poll_lock <= 1'b0;
    end
  end

  assign io_bus.o_rd_valid    = r_rd_valid;
  assign io_bus.o_rd_addr     = r_rd_addr;
  assign io_bus.o_rd_mdata    = r_rd_mdata;
  assign io_bus.o_busy        = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign io_bus.o_run_done    = (r_state == S_DONE);
  assign io_bus.o_outstanding = r_outstanding;

`ifdef STRIDED_READ_ENGINE_PERF_EN
  logic [31:0] r_perf_run;
  logic [31:0] r_perf_stall;

  // both counters hold after DONE until the next accepted start
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_perf_run   <= '0;
      r_perf_stall <= '0;
    end else if (w_start_ok) begin
      r_perf_run   <= '0;
      r_perf_stall <= '0;
    end else begin
      if ((r_state != S_IDLE) && (r_perf_run != 32'hFFFF_FFFF)) begin
        r_perf_run <= r_perf_run + 32'd1;
      end
      if ((r_state == S_ISSUE) && !w_run_issue && (r_perf_stall != 32'hFFFF_FFFF)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign io_bus.o_perf_run_cycles   = r_perf_run;
  assign io_bus.o_perf_stall_cycles = r_perf_stall;
`else
  assign io_bus.o_perf_run_cycles   = 32'd0;
  assign io_bus.o_perf_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_strided_read_engine.sv
// Bench for strided_read_engine: scoreboard of expected requests checked by a monitor, per-scenario tasks.
// Second instance with MAX_OUTSTANDING=2 covers the credit limit.
module tb_strided_read_engine;
  localparam int ADDR_W   = 42;
  localparam int STRIDE_W = 16;
  localparam int MDATA_W  = 16;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [MDATA_W-1:0] mdata;
  } req_t;

  typedef struct packed {
    logic [31:0]        due;
    logic [MDATA_W-1:0] mdata;
  } pend_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  strided_read_engine_if #(.ADDR_W(ADDR_W), .STRIDE_W(STRIDE_W), .MDATA_W(MDATA_W)) bus ();
  strided_read_engine_if #(.ADDR_W(ADDR_W), .STRIDE_W(STRIDE_W), .MDATA_W(MDATA_W)) bus2 ();

  strided_read_engine #(
    .ADDR_W(ADDR_W), .MAX_OUTSTANDING(64), .STRIDE_W(STRIDE_W), .MDATA_W(MDATA_W), .RUN_TAG(1'b1)
  ) dut (
    .i_clk(clk), .i_reset(rst), .io_bus(bus.slave)
  );

  strided_read_engine #(
    .ADDR_W(ADDR_W), .MAX_OUTSTANDING(2), .STRIDE_W(STRIDE_W), .MDATA_W(MDATA_W), .RUN_TAG(1'b1)
  ) dut2 (
    .i_clk(clk), .i_reset(rst), .io_bus(bus2.slave)
  );

  req_t  exp_q[$];
  pend_t pend_q[$];
  int    n_chk = 0;
  int    n_pass = 0;
  int    cyc = 0;
  bit    auto_rsp = 1'b0;
  logic  man_vld = 1'b0;
  logic [MDATA_W-1:0] man_mdata = '0;

  // Monitor: checks every request against the scoreboard and returns run responses 3 cycles later.
  initial begin
    req_t  got;
    req_t  want;
    pend_t p;
    bus.i_rsp_valid = 1'b0;
    bus.i_rsp_mdata = '0;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (!rst && bus.o_rd_valid) begin
        got.addr  = bus.o_rd_addr;
        got.mdata = bus.o_rd_mdata;
        n_chk++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_unexpected_req got addr=%h mdata=%h want no request", got.addr, got.mdata);
        end else begin
          want = exp_q.pop_front();
          if (got !== want)
            $display("FAIL sb_req got addr=%h mdata=%h want addr=%h mdata=%h",
                     got.addr, got.mdata, want.addr, want.mdata);
          else
            n_pass++;
        end
        if (auto_rsp && bus.o_rd_mdata[MDATA_W-1]) begin
          p.due   = 32'(cyc + 3);
          p.mdata = bus.o_rd_mdata;
          pend_q.push_back(p);
        end
      end
      if (auto_rsp && (pend_q.size() != 0) && (pend_q[0].due == 32'(cyc))) begin
        p = pend_q.pop_front();
        bus.i_rsp_valid = 1'b1;
        bus.i_rsp_mdata = p.mdata;
      end else begin
        bus.i_rsp_valid = man_vld;
        bus.i_rsp_mdata = man_mdata;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [MDATA_W-1:0] m);
    req_t r;
    r.addr  = a;
    r.mdata = m;
    exp_q.push_back(r);
  endtask

  task automatic start_run(input logic [ADDR_W-1:0] a, input logic [31:0] n, input logic [STRIDE_W-1:0] s);
    bus.i_start_addr = a;
    bus.i_num_cls    = n;
    bus.i_stride     = s;
    bus.i_start      = 1'b1;
    step();
    bus.i_start      = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) step();
    n_chk++; if (bus.o_rd_valid !== 1'b0) $display("FAIL reset_rd_valid got=%b want=0", bus.o_rd_valid); else n_pass++;
    n_chk++; if (bus.o_busy !== 1'b0 || bus.o_run_done !== 1'b0)
      $display("FAIL reset_busy_done got=%b%b want=00", bus.o_busy, bus.o_run_done); else n_pass++;
    n_chk++; if (bus.o_outstanding !== 9'd0) $display("FAIL reset_outstanding got=%0d want=0", bus.o_outstanding); else n_pass++;
    n_chk++; if (bus.o_rd_addr !== '0 || bus.o_rd_mdata !== '0)
      $display("FAIL reset_addr_mdata got=%h/%h want=0/0", bus.o_rd_addr, bus.o_rd_mdata); else n_pass++;
    n_chk++; if (bus.o_perf_run_cycles !== 32'd0 || bus.o_perf_stall_cycles !== 32'd0)
      $display("FAIL reset_perf got=%0d/%0d want=0/0", bus.o_perf_run_cycles, bus.o_perf_stall_cycles); else n_pass++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic_run();
    int first = -1, last = -1, nreq = 0, ndone = 0;
    bit clean_at_done = 1'b0;
    for (int i = 0; i < 4; i++) push_exp(ADDR_W'(32'h100 + i), {1'b1, 15'(i)});
    auto_rsp = 1'b1;
    start_run(42'h100, 32'd4, 16'd1);
    n_chk++; if (bus.o_busy !== 1'b1) $display("FAIL basic_busy got=%b want=1", bus.o_busy); else n_pass++;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.o_rd_valid) begin
        if (first < 0) first = k;
        last = k;
        nreq++;
      end
      if (bus.o_run_done) begin
        ndone++;
        clean_at_done = (pend_q.size() == 0) && (bus.o_outstanding == 9'd0);
      end
    end
    n_chk++; if (nreq != 4 || (last - first) != 3)
      $display("FAIL basic_req_count got=%0d span=%0d want=4 span=3", nreq, last - first); else n_pass++;
    n_chk++; if (ndone != 1) $display("FAIL basic_run_done_pulses got=%0d want=1", ndone); else n_pass++;
    n_chk++; if (!clean_at_done) $display("FAIL basic_done_after_rsp got=%b want=1", clean_at_done); else n_pass++;
    n_chk++; if (exp_q.size() != 0) $display("FAIL basic_sb_left got=%0d want=0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_stride_wrap();
    bit done = 1'b0;
    push_exp(42'h3FF_FFFF_FFFE, 16'h8000);
    push_exp(42'h000_0000_0001, 16'h8001);
    push_exp(42'h000_0000_0004, 16'h8002);
    start_run(42'h3FF_FFFF_FFFE, 32'd3, 16'd3);
    for (int k = 0; k < 40 && !done; k++) begin
      step();
      if (bus.o_run_done) done = 1'b1;
    end
    n_chk++; if (!done) $display("FAIL wrap_run_done got=0 want=1 within 40 cycles"); else n_pass++;
    n_chk++; if (exp_q.size() != 0) $display("FAIL wrap_sb_left got=%0d want=0", exp_q.size()); else n_pass++;
    step();
  endtask

  task automatic test_credit_limit();
    int nreq = 0;
    bus2.i_start_addr = 42'h500;
    bus2.i_num_cls    = 32'd5;
    bus2.i_stride     = 16'd1;
    bus2.i_start      = 1'b1;
    step();
    bus2.i_start      = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (bus2.o_rd_valid) nreq++;
    end
    n_chk++; if (nreq != 2) $display("FAIL credit_issued got=%0d want=2", nreq); else n_pass++;
    n_chk++; if (bus2.o_outstanding !== 9'd2) $display("FAIL credit_outstanding got=%0d want=2", bus2.o_outstanding); else n_pass++;
    bus2.i_rsp_valid = 1'b1;
    bus2.i_rsp_mdata = 16'h8000;
    step();
    bus2.i_rsp_valid = 1'b0;
    n_chk++; if (bus2.o_rd_valid !== 1'b0 || bus2.o_outstanding !== 9'd1)
      $display("FAIL credit_release got vld=%b out=%0d want vld=0 out=1", bus2.o_rd_valid, bus2.o_outstanding); else n_pass++;
    step();
    n_chk++; if (bus2.o_rd_valid !== 1'b1 || bus2.o_rd_addr !== 42'h502 || bus2.o_rd_mdata !== 16'h8002)
      $display("FAIL credit_next_req got vld=%b addr=%h mdata=%h want 1/502/8002",
               bus2.o_rd_valid, bus2.o_rd_addr, bus2.o_rd_mdata); else n_pass++;
    nreq = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (bus2.o_rd_valid) nreq++;
    end
    n_chk++; if (nreq != 0 || bus2.o_outstanding !== 9'd2)
      $display("FAIL credit_no_extra got=%0d out=%0d want=0 out=2", nreq, bus2.o_outstanding); else n_pass++;
  endtask

  task automatic test_stall();
    int nreq = 0, nstall = 0, both = 0;
    bit done = 1'b0;
    logic [8:0] prev_out;
    for (int i = 0; i < 8; i++) push_exp(ADDR_W'(32'h200 + i), {1'b1, 15'(i)});
    start_run(42'h200, 32'd8, 16'd1);
    for (int k = 0; k < 10 && nreq < 2; k++) begin
      step();
      if (bus.o_rd_valid) nreq++;
    end
    bus.i_stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      if (bus.o_rd_valid) nstall++;
    end
    bus.i_stall = 1'b0;
    n_chk++; if (nreq != 2 || nstall != 0)
      $display("FAIL stall_quiet got pre=%0d during=%0d want pre=2 during=0", nreq, nstall); else n_pass++;
    prev_out = bus.o_outstanding;
    for (int k = 0; k < 60 && !done; k++) begin
      step();
      if (bus.o_rd_valid && bus.i_rsp_valid && bus.i_rsp_mdata[MDATA_W-1] && prev_out != 9'd0) begin
        both++;
        n_chk++; if (bus.o_outstanding !== prev_out)
          $display("FAIL stall_inc_dec got=%0d want=%0d", bus.o_outstanding, prev_out); else n_pass++;
      end
      prev_out = bus.o_outstanding;
      if (bus.o_run_done) done = 1'b1;
    end
    n_chk++; if (both == 0 || !done)
      $display("FAIL stall_overlap_done got overlap=%0d done=%b want overlap>0 done=1", both, done); else n_pass++;
    n_chk++; if (exp_q.size() != 0) $display("FAIL stall_sb_left got=%0d want=0", exp_q.size()); else n_pass++;
    step();
  endtask

  task automatic test_zero_and_poll();
    int nreq = 0;
    start_run(42'h700, 32'd0, 16'd1);
    n_chk++; if (bus.o_run_done !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_rd_valid !== 1'b0)
      $display("FAIL zero_done got done=%b busy=%b vld=%b want 1/0/0", bus.o_run_done, bus.o_busy, bus.o_rd_valid); else n_pass++;
    step();
    n_chk++; if (bus.o_run_done !== 1'b0) $display("FAIL zero_done_pulse got=%b want=0", bus.o_run_done); else n_pass++;
    bus.i_ctrl_addr = 42'h2AB_CDEF;
    push_exp(42'h2AB_CDEF, 16'h0000);
    bus.i_ctrl_poll_req = 1'b1;
    step();
    bus.i_ctrl_poll_req = 1'b0;
    if (bus.o_rd_valid) nreq++;
    step();
    bus.i_ctrl_poll_req = 1'b1;
    step();
    bus.i_ctrl_poll_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (bus.o_rd_valid) nreq++;
      step();
    end
    n_chk++; if (nreq != 1) $display("FAIL poll_once got=%0d want=1", nreq); else n_pass++;
    man_vld = 1'b1;
    man_mdata = 16'h0000;
    bus.i_ctrl_ack = 1'b1;
    step();
    man_vld = 1'b0;
    bus.i_ctrl_ack = 1'b0;
    step();
    n_chk++; if (bus.o_outstanding !== 9'd0) $display("FAIL poll_rsp_no_credit got=%0d want=0", bus.o_outstanding); else n_pass++;
    push_exp(42'h2AB_CDEF, 16'h0000);
    bus.i_ctrl_poll_req = 1'b1;
    step();
    bus.i_ctrl_poll_req = 1'b0;
    n_chk++; if (bus.o_rd_valid !== 1'b1) $display("FAIL poll_after_ack got=%b want=1", bus.o_rd_valid); else n_pass++;
    bus.i_ctrl_ack = 1'b1;
    step();
    bus.i_ctrl_ack = 1'b0;
    n_chk++; if (exp_q.size() != 0) $display("FAIL poll_sb_left got=%0d want=0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    bit got = 1'b0;
    bit done = 1'b0;
    auto_rsp = 1'b0;
    for (int i = 0; i < 3; i++) push_exp(ADDR_W'(32'h300 + i), {1'b1, 15'(i)});
    start_run(42'h300, 32'd3, 16'd1);
    for (int k = 0; k < 20 && !got; k++) begin
      step();
      if (bus.o_outstanding == 9'd3) got = 1'b1;
    end
    n_chk++; if (!got || bus.o_busy !== 1'b1 || bus.o_rd_valid !== 1'b1)
      $display("FAIL rst_pre got reached=%b busy=%b vld=%b want 1/1/1", got, bus.o_busy, bus.o_rd_valid); else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_chk++; if (bus.o_rd_valid !== 1'b0 || bus.o_outstanding !== 9'd0 || bus.o_busy !== 1'b0)
      $display("FAIL rst_async got vld=%b out=%0d busy=%b want 0/0/0", bus.o_rd_valid, bus.o_outstanding, bus.o_busy); else n_pass++;
    step();
    rst = 1'b0;
    step();
    man_vld = 1'b1;
    man_mdata = 16'h8001;
    step();
    man_vld = 1'b0;
    step();
    n_chk++; if (bus.o_outstanding !== 9'd0) $display("FAIL rst_stray_rsp got=%0d want=0", bus.o_outstanding); else n_pass++;
    auto_rsp = 1'b1;
    push_exp(42'h400, 16'h8000);
    push_exp(42'h401, 16'h8001);
    start_run(42'h400, 32'd2, 16'd1);
    for (int k = 0; k < 40 && !done; k++) begin
      step();
      if (bus.o_run_done) done = 1'b1;
    end
    n_chk++; if (!done || exp_q.size() != 0 || bus.o_outstanding !== 9'd0)
      $display("FAIL rst_new_run got done=%b left=%0d out=%0d want 1/0/0", done, exp_q.size(), bus.o_outstanding); else n_pass++;
    auto_rsp = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    bus.i_stall = 1'b0; bus.i_start = 1'b0; bus.i_start_addr = '0; bus.i_num_cls = '0;
    bus.i_stride = '0; bus.i_ctrl_poll_req = 1'b0; bus.i_ctrl_addr = '0; bus.i_ctrl_ack = 1'b0;
    bus2.i_stall = 1'b0; bus2.i_start = 1'b0; bus2.i_start_addr = '0; bus2.i_num_cls = '0;
    bus2.i_stride = '0; bus2.i_ctrl_poll_req = 1'b0; bus2.i_ctrl_addr = '0; bus2.i_ctrl_ack = 1'b0;
    bus2.i_rsp_valid = 1'b0; bus2.i_rsp_mdata = '0;
    test_reset();
    test_basic_run();
    test_stride_wrap();
    test_credit_limit();
    test_stall();
    test_zero_and_poll();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/strided_read_engine.md
Name: strided_read_engine

Overview:
- Parametrised successor to the single-stream CCI read engine.
- Issues one read run of N cache lines from a start address with a programmable stride.
- Bounds in-flight reads with a credit counter and retires them on response.
- Also issues single control-poll reads while idle.
- Sits between the AFU control FSM and the c0 Tx request port; observes c0 Rx responses for credit return.

Parameters:
- ADDR_W, 42, cache-line address width; all address arithmetic is modulo 2^ADDR_W.
- MAX_OUTSTANDING, 64, maximum run reads in flight (1..256).
- STRIDE_W, 16, width of the line-stride input.
- MDATA_W, 16, request/response mdata width.
- RUN_TAG, 1'b1, value of mdata[MDATA_W-1] on run reads; control reads carry the complement.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  Tx almost-full; no new request is issued in a cycle where it is high
- start  in  1  one-cycle pulse; latches start_addr, num_cls and stride; honoured only in IDLE
- start_addr  in  ADDR_W  first line address
- num_cls  in  32  number of lines to read
- stride  in  STRIDE_W  address increment between lines, unsigned; 0 means re-read the same line
- ctrl_poll_req  in  1  request one control read; honoured only in IDLE
- ctrl_addr  in  ADDR_W  control-block line address
- ctrl_ack  in  1  control response consumed; releases the poll lock
- rsp_valid  in  1  c0 Rx read response valid
- rsp_mdata  in  MDATA_W  mdata of the response
- rd_valid  out  1  read request valid, registered
- rd_addr  out  ADDR_W  request address
- rd_mdata  out  MDATA_W  request mdata
- busy  out  1  high in ISSUE or DRAIN
- run_done  out  1  one-cycle pulse when the run fully completes
- outstanding  out  9  current in-flight run read count

Behaviour:
- Reset values:
  - State is IDLE.
  - rd_valid, run_done, busy and outstanding are 0; the poll lock is clear.
  - rd_addr and rd_mdata are 0.
- States and transitions:
  - IDLE -> ISSUE on start when num_cls != 0.
  - IDLE -> DONE on start when num_cls == 0.
  - ISSUE -> DRAIN in the cycle the last line is issued.
  - DRAIN -> DONE when outstanding reaches 0.
  - DONE -> IDLE after exactly 1 cycle; run_done is high for that cycle only.
- Issue condition in ISSUE: ~stall && remaining != 0 && outstanding < MAX_OUTSTANDING.
  - On issue: rd_valid=1 on the next cycle with rd_addr=cur_addr.
  - rd_mdata = {RUN_TAG, seq[MDATA_W-2:0]}, where seq starts at 0 and increments per issue.
  - cur_addr += zero-extended stride; wrap-around modulo 2^ADDR_W is permitted.
  - remaining -= 1.
- Request latency: exactly 1 cycle from the issue decision to rd_valid. rd_valid is never high for 2 requests in the same cycle.
- Credits:
  - outstanding increments on a run issue.
  - It decrements on rsp_valid with rsp_mdata[MDATA_W-1]==RUN_TAG.
  - Simultaneous increment and decrement leaves it unchanged.
  - A run response while outstanding==0 is ignored; the counter saturates at 0.
- Exactly num_cls lines are issued; no extra line past the end.
- Control poll:
  - In IDLE with the poll lock clear, ~stall and ctrl_poll_req: issue one read.
  - The read has rd_addr=ctrl_addr and rd_mdata={~RUN_TAG, 0}; set the poll lock.
  - The lock clears on ctrl_ack.
  - ctrl_poll_req while locked or not IDLE is dropped.
  - Control responses do not affect outstanding.
- Simultaneous start and ctrl_poll_req in IDLE: start wins and the poll is dropped.
- start when not in IDLE is ignored; latched parameters are unchanged.
- Asynchronous reset mid-run:
  - rd_valid drops immediately and all counters clear.
  - Responses arriving after reset are treated as stray (ignored at outstanding==0).

Optional Feature:
- Macro: STRIDED_READ_ENGINE_PERF_EN.
- With the macro defined, two extra outputs are present:
  - perf_run_cycles (32): counts cycles from leaving IDLE through DONE.
  - perf_stall_cycles (32): counts ISSUE cycles where issue was blocked by stall or credit.
  - Both clear on an accepted start, hold after DONE, and saturate at all-ones.
- Without the macro, both ports are still present and tied to 0; no counter logic is inferred.

Test Plan:
- Basic run: start_addr=0x100, num_cls=4, stride=1, no stall, responses returned 3 cycles after each request -> rd_addr 0x100,0x101,0x102,0x103 on consecutive cycles with mdata seq 0..3; run_done pulses once, after the 4th response.
- Stride and wrap: ADDR_W=42, start_addr=2^42-2, stride=3, num_cls=3 -> rd_addr = 2^42-2, 1, 4.
- Credit limit: MAX_OUTSTANDING=2, num_cls=5, responses withheld -> exactly 2 requests issue and outstanding=2. Releasing one response causes exactly one further request 1 cycle later.
- Stall plus simultaneous rsp/issue: stall high for 5 cycles mid-run -> no rd_valid during the stall. A cycle with both issue and run response leaves outstanding unchanged.
- Zero-length and poll: start with num_cls=0 -> no rd_valid and run_done 1 cycle after start. Then ctrl_poll_req twice before ctrl_ack -> exactly one control read with rd_addr=ctrl_addr and mdata MSB=~RUN_TAG.
- Reset mid-run: assert reset during DRAIN with outstanding=3 -> state IDLE, outstanding=0, rd_valid=0. A late run response keeps outstanding at 0, and a new start runs normally.
